jt7759_pack: RTL
================

JT7759_PACK -- requirements
Module: jt7759_pack

Interface
REQ-001 clk  input  1  single clock; every register updates on its rising edge.
REQ-002 rstn  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  one-cycle pulse; starts a stream; sampled only in IDLE.
REQ-004 base_addr  input  17  byte address of the first command byte; latched on start.
REQ-005 divby  input  6  sample-rate divider; placed in bits 5:0 of every play command; latched at each block's command emission.
REQ-006 nib_valid / nib_ready  input / output  1 / 1  ADPCM nibble handshake; a nibble transfers when both are high.
REQ-007 nib  input  4  ADPCM nibble; the first nibble of a pair goes in byte bits 7:4.
REQ-008 sil_req, sil_len  input  1, 6  silence request and its length in 128-tick units; sampled in FILL.
REQ-009 stop  input  1  pulse; ends the stream; sampled in FILL.
REQ-010 wr_en, wr_addr, wr_data  output  1, 17, 8  memory write request; all three hold stable until wr_ok.
REQ-011 wr_ok  input  1  write accepted; valid only while wr_en is high.
REQ-012 busy, done  output  1, 1  busy is high in every state except IDLE; done is a one-cycle pulse on entering IDLE from END.

Function
REQ-013 States: IDLE, SIGN, FILL, CMD, CNT, DATA, SIL, END.
REQ-014 Transitions: IDLE -start-> SIGN (with macro) or FILL. In FILL, a full buffer, sil_req or stop -> CMD if the buffer is non-empty. Otherwise sil_req -> SIL and stop -> END. CMD -> CNT (partial block) or DATA. CNT -> DATA. DATA -> SIL, END or FILL, per the pending cause. SIL -> FILL. END -> IDLE.
REQ-015 nib_ready is high only in FILL with fewer than 256 buffered nibbles; nibbles arrive at up to one per cycle.
REQ-016 Buffer: 128 bytes of packed pairs plus a 9-bit nibble count, cleared when DATA completes.
REQ-017 Full block of 256 nibbles: CMD writes 0x40|divby; DATA then writes 128 bytes.
REQ-018 Partial block of N nibbles (1..255): CMD writes 0x80|divby; CNT writes N-1; DATA writes ceil(N/2) bytes. When N is odd, the final byte's bits 3:0 are 0.
REQ-019 SIL writes 0x00|sil_len. A sil_len of 0 is written as 0x01, because 0x00 is the end marker.
REQ-020 END: if no non-zero byte has been written since start, first write 0x01; then write 0x00.
REQ-021 sil_req and stop high in the same cycle: the silence is emitted first, then the stream ends.
REQ-022 sil_req or stop with a non-empty buffer: the buffer is flushed as a block first, and the request is held pending.
REQ-023 At most one write is outstanding. wr_addr increments by 1 per accepted write and wraps modulo 2^17.
REQ-024 Latency: the first wr_en is asserted on the cycle after entry into CMD, SIL or END.
REQ-025 start outside IDLE is ignored.

Reset
REQ-026 While rstn is low at a clock edge: state becomes IDLE; wr_en, busy, done and nib_ready become 0; wr_addr and wr_data become 0; buffer count is cleared.
REQ-027 Reset mid-write abandons the write; the memory contents written so far are undefined for the reader.

Configuration
REQ-028 JT7759_PACK_SIGN_EN defined: on start, the SIGN state first writes 5A, A5, 69, 55 to addresses 1..4, then enters FILL.
REQ-029 JT7759_PACK_SIGN_EN undefined: the SIGN state is absent and start goes directly to FILL.

Structure
REQ-030 Package jt7759_pkg holds:
- command opcodes: SIL=2'd0, PLAY256=2'd1, PLAYN=2'd2, REPEAT=2'd3;
- end marker 8'h00;
- the 4 signature bytes;
- state encodings.
REQ-031 Sub-module jt7759_pack_buf is a 128x8 single-port buffer with a nibble write-merge port.

Verification
REQ-032 start with base_addr=0x100 and divby=0x10, 256 nibbles, then stop -> writes: 0x50 @0x100; 128 data bytes; 0x00 @0x181; done pulse.
REQ-033 5 nibbles 1,2,3,4,5, then stop -> writes 0x90, 0x04, 0x12, 0x34, 0x50, 0x00.
REQ-034 stop with an empty buffer -> writes 0x01 then 0x00.
REQ-035 3 nibbles, then sil_req with sil_len=0, same cycle as stop -> writes 0x80|divby, 0x02, two data bytes, 0x01, 0x00.
REQ-036 wr_ok held low for 10 cycles -> wr_en, wr_addr and wr_data stay stable; nib_ready stays low outside FILL.
REQ-037 With JT7759_PACK_SIGN_EN: start -> first writes are 5A@1, A5@2, 69@3, 55@4. Second run: rstn asserted mid-DATA -> all outputs reach reset values after one edge.

Source files
------------

// File: rtl/jt7759_pkg.sv
// Shared types and constants for the jt7759 ADPCM stream packer.
package jt7759_pkg;

    localparam int unsigned AW        = 17;
    localparam int unsigned DW        = 8;
    localparam int unsigned NW        = 4;
    localparam int unsigned LW        = 6;
    localparam int unsigned CW        = 9;
    localparam int unsigned BAW       = 7;
    localparam int unsigned FULL_NIBS = 256;

    typedef enum logic [1:0] {
        OP_SIL     = 2'd0,
        OP_PLAY256 = 2'd1,
        OP_PLAYN   = 2'd2,
        OP_REPEAT  = 2'd3
    } op_e;

    localparam logic [DW-1:0] END_MARK = 8'h00;

    localparam logic [DW-1:0] SIG0 = 8'h5A;
    localparam logic [DW-1:0] SIG1 = 8'hA5;
    localparam logic [DW-1:0] SIG2 = 8'h69;
    localparam logic [DW-1:0] SIG3 = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SIGN, ST_FILL, ST_CMD, ST_CNT, ST_DATA, ST_SIL, ST_END
    } state_e;

    function automatic logic [DW-1:0] sig_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return SIG0;
            2'd1:    return SIG1;
            2'd2:    return SIG2;
            default: return SIG3;
        endcase
    endfunction

endpackage

// File: rtl/jt7759_pack_if.sv
// Nibble input handshake and memory write port of the packer.
interface jt7759_pack_if;
    import jt7759_pkg::*;

    logic          nib_valid;
    logic          nib_ready;
    logic [NW-1:0] nib;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ok;

    modport master (
        input  nib_valid, nib, wr_ok,
        output nib_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output nib_valid, nib, wr_ok,
        input  nib_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/jt7759_pack_buf.sv
// 128x8 single-port block buffer; a high-nibble write clears the low nibble
// so an odd-length block ends with a zero pad.
module jt7759_pack_buf
    import jt7759_pkg::*;
(
    input  logic           clk,
    input  logic           we,
    input  logic           hi,
    input  logic [BAW-1:0] addr,
    input  logic [NW-1:0]  nib,
    output logic [DW-1:0]  rdata
);
    logic [DW-1:0] mem [0:(1<<BAW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            if (hi) mem[addr] <= {nib, NW'(0)};
            else    mem[addr][NW-1:0] <= nib;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/jt7759_pack.sv
// jt7759 ADPCM stream packer: buffers nibble pairs and writes command/data bytes.
// Define JT7759_PACK_SIGN_EN to emit the 4-byte signature at addresses 1..4 on start.
module jt7759_pack
    import jt7759_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic [AW-1:0]  base_addr,
    input  logic [LW-1:0]  divby,
    input  logic           sil_req,
    input  logic [LW-1:0]  sil_len,
    input  logic           stop,
    output logic           busy,
    output logic           done,
    jt7759_pack_if.master  bus
);
    state_e        state, state_nx;
    logic [AW-1:0] addr, addr_nx, wr_addr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    bidx, bidx_nx, nbytes;
    logic [DW-1:0] wr_data_nx, rdata;
    logic [LW-1:0] len_q, len_nx;
    logic          rd_ok, rd_ok_nx, nz_seen, nz_nx;
    logic          pend_sil, pend_stop, ps_nx, pt_nx;
    logic          wr_en_nx, ready_nx, busy_nx, done_nx;
    logic          accept, xfer, full_blk, stop_e, sil_e;
`ifdef JT7759_PACK_SIGN_EN
    logic [1:0]    step, step_nx;
`endif

    assign accept   = bus.wr_en & bus.wr_ok;
    assign xfer     = bus.nib_valid & bus.nib_ready;
    assign full_blk = (cnt == CW'(FULL_NIBS));
    assign nbytes   = 8'((cnt + CW'(1)) >> 1);
    // a stop left pending by a flush or silence outranks a new sil_req
    assign stop_e   = stop | pend_stop;
    assign sil_e    = sil_req & ~pend_stop;

    jt7759_pack_buf u_buf (
        .clk   (clk),
        .we    (xfer),
        .hi    (~cnt[0]),
        .addr  ((state == ST_FILL) ? cnt[BAW:1] : bidx[BAW-1:0]),
        .nib   (bus.nib),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            addr          <= '0;
            cnt           <= '0;
            bidx          <= '0;
            len_q         <= '0;
            rd_ok         <= 1'b0;
            nz_seen       <= 1'b0;
            pend_sil      <= 1'b0;
            pend_stop     <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.nib_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef JT7759_PACK_SIGN_EN
            step          <= '0;
`endif
        end else begin
            state         <= state_nx;
            addr          <= addr_nx;
            cnt           <= cnt_nx;
            bidx          <= bidx_nx;
            len_q         <= len_nx;
            rd_ok         <= rd_ok_nx;
            nz_seen       <= nz_nx;
            pend_sil      <= ps_nx;
            pend_stop     <= pt_nx;
            bus.wr_en     <= wr_en_nx;
            bus.wr_addr   <= wr_addr_nx;
            bus.wr_data   <= wr_data_nx;
            bus.nib_ready <= ready_nx;
            busy          <= busy_nx;
            done          <= done_nx;
`ifdef JT7759_PACK_SIGN_EN
            step          <= step_nx;
`endif
        end
    end

    // Each write state issues when no write is open and advances on accept.
    always_comb begin
        state_nx   = state;
        addr_nx    = addr;
        cnt_nx     = cnt;
        bidx_nx    = bidx;
        len_nx     = len_q;
        rd_ok_nx   = rd_ok;
        nz_nx      = nz_seen;
        ps_nx      = pend_sil;
        pt_nx      = pend_stop;
        wr_en_nx   = bus.wr_en;
        wr_addr_nx = bus.wr_addr;
        wr_data_nx = bus.wr_data;
        done_nx    = 1'b0;
`ifdef JT7759_PACK_SIGN_EN
        step_nx    = step;
`endif

        if (accept) begin
            wr_en_nx = 1'b0;
            if (bus.wr_data != END_MARK) nz_nx = 1'b1;
            if (state != ST_SIGN) addr_nx = addr + AW'(1);
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_nx = base_addr;
                    cnt_nx  = '0;
                    bidx_nx = '0;
                    nz_nx   = 1'b0;
                    ps_nx   = 1'b0;
                    pt_nx   = 1'b0;
`ifdef JT7759_PACK_SIGN_EN
                    step_nx  = '0;
                    state_nx = ST_SIGN;
`else
                    state_nx = ST_FILL;
`endif
                end
            end
`ifdef JT7759_PACK_SIGN_EN
            ST_SIGN: begin
                if (!bus.wr_en) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = AW'(step) + AW'(1);
                    wr_data_nx = sig_byte(step);
                end else if (accept) begin
                    step_nx = step + 2'd1;
                    if (step == 2'd3) state_nx = ST_FILL;
                end
            end
`endif
            ST_FILL: begin
                if (xfer) cnt_nx = cnt + CW'(1);
                if (sil_e || stop_e) begin
                    ps_nx = sil_e;
                    pt_nx = stop_e;
                    if (sil_e) len_nx = sil_len;
                    if (cnt_nx != '0) state_nx = ST_CMD;
                    else if (sil_e)   state_nx = ST_SIL;
                    else              state_nx = ST_END;
                end else if (cnt_nx == CW'(FULL_NIBS)) begin
                    state_nx = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!bus.wr_en) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = addr;
                    wr_data_nx = full_blk ? {2'(OP_PLAY256), divby} : {2'(OP_PLAYN), divby};
                end else if (accept) begin
                    bidx_nx  = '0;
                    rd_ok_nx = 1'b0;
                    state_nx = full_blk ? ST_DATA : ST_CNT;
                end
            end
            ST_CNT: begin
                if (!bus.wr_en) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = addr;
                    wr_data_nx = DW'(cnt - CW'(1));
                end else if (accept) begin
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                // one idle cycle per byte lets the buffer read settle
                if (!bus.wr_en) begin
                    if (!rd_ok) begin
                        rd_ok_nx = 1'b1;
                    end else begin
                        rd_ok_nx   = 1'b0;
                        wr_en_nx   = 1'b1;
                        wr_addr_nx = addr;
                        wr_data_nx = rdata;
                    end
                end else if (accept) begin
                    if (bidx + 8'd1 == nbytes) begin
                        cnt_nx  = '0;
                        bidx_nx = '0;
                        if (pend_sil)       state_nx = ST_SIL;
                        else if (pend_stop) state_nx = ST_END;
                        else                state_nx = ST_FILL;
                    end else begin
                        bidx_nx = bidx + 8'd1;
                    end
                end
            end
            ST_SIL: begin
                if (!bus.wr_en) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = addr;
                    wr_data_nx = {2'(OP_SIL), (len_q == '0) ? LW'(1) : len_q};
                end else if (accept) begin
                    ps_nx    = 1'b0;
                    state_nx = ST_FILL;
                end
            end
            ST_END: begin
                if (!bus.wr_en) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = addr;
                    wr_data_nx = nz_seen ? END_MARK : 8'h01;
                end else if (accept && bus.wr_data == END_MARK) begin
                    pt_nx    = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        ready_nx = (state_nx == ST_FILL) && !pt_nx && (cnt_nx < CW'(FULL_NIBS));
        busy_nx  = (state_nx != ST_IDLE);
    end
endmodule
